shift_reg_univ: RTL and testbench
=================================

# shift_reg_univ

Parametrised universal shift register: DEPTH stages of WIDTH-bit lanes with selectable up/down shift, rotate, parallel load and clear. A modulo-DEPTH frame counter pulses once per DEPTH shifts, so the block also works as a serial-to-parallel deserializer. It is the drop-in successor to the fixed 4-stage 1-bit shift chain and is used for serial capture, delay lines and word assembly.

## Interface
- WIDTH, 1: bits per stage (lane width); ≥1
- DEPTH, 4: number of stages; ≥2
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  asynchronous, active-low reset; clears all state immediately on assertion
- mode  in  3  operation select, shift_pkg::sh_mode_t; sampled on each rising clk
- sin_up  in  WIDTH  serial input entering stage 0 on SH_UP
- sin_dn  in  WIDTH  serial input entering stage DEPTH-1 on SH_DOWN
- pin  in  DEPTH*WIDTH  parallel load data; stage i = pin[i*WIDTH +: WIDTH]
- pout  out  DEPTH*WIDTH  parallel view of all stages, same packing as pin
- sout_up  out  WIDTH  stage DEPTH-1 (exits on SH_UP)
- sout_dn  out  WIDTH  stage 0 (exits on SH_DOWN)
- frame_cnt  out  $clog2(DEPTH)  shifts since last frame boundary, 0..DEPTH-1
- frame  out  1  one-cycle pulse: DEPTH shifts completed since last boundary

## Operation
- Modes: SH_HOLD=0, SH_UP=1, SH_DOWN=2, SH_ROT_UP=3, SH_ROT_DOWN=4, SH_LOAD=5, SH_CLEAR=6; code 7 reserved, behaves as SH_HOLD.
- SH_UP: stage[0]<=sin_up, stage[i]<=stage[i-1].
- SH_DOWN: stage[DEPTH-1]<=sin_dn, stage[i]<=stage[i+1].
- SH_ROT_UP: stage[0]<=stage[DEPTH-1], others as SH_UP. SH_ROT_DOWN is the mirror.
- SH_LOAD: stage[i]<=pin lane i; frame_cnt<=0; no frame pulse.
- SH_CLEAR: all stages 0, frame_cnt<=0, frame<=0.
- Frame counter: advances only on SH_UP or SH_DOWN. Rotate, hold and reserved modes leave it unchanged. If frame_cnt==DEPTH-1 on a shift: frame_cnt<=0 and frame<=1. Otherwise frame_cnt+1 and frame<=0. In every non-shift cycle frame<=0.
- Mixing up and down shifts within a frame is legal; both count.
- sout_up, sout_dn and pout are direct register taps, with no combinational path from any input.

## Timing
- Reset (async assert, no clk needed): all stages, pout, sout_up, sout_dn, frame_cnt and frame are 0. Deassertion is synchronised externally; the first active edge after deassertion executes mode normally.
- Latency: sin_up appears on pout lane 0 one cycle after the edge. It reaches sout_up after DEPTH edges of SH_UP.
- frame rises on the same edge that writes the DEPTH-th shifted lane, so pout is a complete new word in that cycle.
- Reset mid-frame discards partial frame_cnt; no frame pulse is issued for the partial word.
- Back-to-back frames: continuous shifting pulses frame every DEPTH cycles with no gap cycle.
- DEPTH a power of two: the counter wrap is explicit at DEPTH-1, not width overflow. The same rule applies for non-power-of-two DEPTH (e.g. 5 wraps 4→0).

## Structure
- shift_pkg: sh_mode_t enum (3-bit, encodings above), SH_MODE_W=3.
- Sub-module shift_frame_cnt (param DEPTH; in clk, reset, shift_en, clr; out frame_cnt, frame). It holds the counter and pulse logic. The stage array and mode mux live in shift_reg_univ.

## Test plan
- WIDTH=1, DEPTH=4: reset low mid-cycle → all outputs 0 immediately, without a clk edge.
- SH_UP, sin_up=1,0,1,1 on four edges → pout=4'b1011, sout_up=1. frame_cnt goes 1,2,3,0. frame=1 only after the 4th edge.
- SH_LOAD pin=4'b0001, then 4×SH_ROT_UP → pout 0010, 0100, 1000, 0001. frame stays 0 and frame_cnt stays 0.
- From 0, SH_DOWN sin_dn=1 ×2 → pout 1000, 1100, sout_dn=0. Then SH_CLEAR → pout 0, frame_cnt 0.
- WIDTH=8, DEPTH=3: continuous SH_UP of 0x11,0x22,…,0x66 → frame pulses after the 3rd and 6th edges, with pout=0x112233 then 0x445566.
- Mode 7 and SH_HOLD interleaved in a shift stream → state and frame_cnt unchanged. The frame pulse is delayed by exactly the number of hold cycles.

Source files
------------

// File: rtl/shift_reg_univ_pkg.sv
// Shared types for the universal shift register: operation modes and a
// helper that identifies the modes which advance the frame counter.
package shift_pkg;

    localparam int SH_MODE_W = 3;

    typedef enum logic [SH_MODE_W-1:0] {
        SH_HOLD     = 3'd0,
        SH_UP       = 3'd1,
        SH_DOWN     = 3'd2,
        SH_ROT_UP   = 3'd3,
        SH_ROT_DOWN = 3'd4,
        SH_LOAD     = 3'd5,
        SH_CLEAR    = 3'd6,
        SH_RSVD     = 3'd7
    } sh_mode_t;

    // Only true shifts consume serial data, so only they count toward a frame.
    function automatic logic is_shift(sh_mode_t m);
        return (m == SH_UP) || (m == SH_DOWN);
    endfunction

endpackage

// File: rtl/shift_reg_univ_if.sv
// Bus bundle between the shift register and its user: mode/serial/parallel
// inputs and the register taps plus frame status.
interface shift_reg_univ_if
    import shift_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
);
    sh_mode_t                     mode;
    logic [WIDTH-1:0]             sin_up;
    logic [WIDTH-1:0]             sin_dn;
    logic [DEPTH*WIDTH-1:0]       pin;
    logic [DEPTH*WIDTH-1:0]       pout;
    logic [WIDTH-1:0]             sout_up;
    logic [WIDTH-1:0]             sout_dn;
    logic [$clog2(DEPTH)-1:0]     frame_cnt;
    logic                         frame;

    modport master (
        output mode, sin_up, sin_dn, pin,
        input  pout, sout_up, sout_dn, frame_cnt, frame
    );

    modport slave (
        input  mode, sin_up, sin_dn, pin,
        output pout, sout_up, sout_dn, frame_cnt, frame
    );
endinterface

// File: rtl/shift_reg_univ_frame_cnt.sv
// Modulo-DEPTH shift counter with a one-cycle pulse on the DEPTH-th shift.
// The wrap is an explicit compare so non-power-of-two depths behave the same.
module shift_frame_cnt #(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      shift_en,
    input  logic                      clr,
    output logic [$clog2(DEPTH)-1:0]  frame_cnt,
    output logic                      frame
);
    localparam int             CW   = $clog2(DEPTH);
    localparam logic [CW-1:0]  LAST = CW'(DEPTH - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_frame;
    logic          w_frame_nxt;

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_frame_nxt = 1'b0;
        if (clr) begin
            w_cnt_nxt = '0;
        end else if (shift_en) begin
            if (r_cnt == LAST) begin
                w_cnt_nxt   = '0;
                w_frame_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_frame <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_frame <= w_frame_nxt;
        end
    end

    assign frame_cnt = r_cnt;
    assign frame     = r_frame;
endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: DEPTH lanes of WIDTH bits with up/down shift,
// rotate, parallel load and clear; all outputs are plain register taps.
module shift_reg_univ
    import shift_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    shift_reg_univ_if.slave  bus
);
    // Lane i of the packed array sits at bits [i*WIDTH +: WIDTH], matching pin/pout.
    logic [DEPTH-1:0][WIDTH-1:0] r_stage;
    logic [DEPTH-1:0][WIDTH-1:0] w_next;
    logic                        w_shift_en;
    logic                        w_clr;
    logic [$clog2(DEPTH)-1:0]    w_frame_cnt;
    logic                        w_frame;

    always_comb begin
        w_next = r_stage;
        case (bus.mode)
            SH_UP:       w_next = {r_stage[DEPTH-2:0], bus.sin_up};
            SH_DOWN:     w_next = {bus.sin_dn, r_stage[DEPTH-1:1]};
            SH_ROT_UP:   w_next = {r_stage[DEPTH-2:0], r_stage[DEPTH-1]};
            SH_ROT_DOWN: w_next = {r_stage[0], r_stage[DEPTH-1:1]};
            SH_LOAD:     w_next = bus.pin;
            SH_CLEAR:    w_next = '0;
            default:     w_next = r_stage;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stage <= '0;
        end else begin
            r_stage <= w_next;
        end
    end

    assign w_shift_en = is_shift(bus.mode);
    assign w_clr      = (bus.mode == SH_LOAD) || (bus.mode == SH_CLEAR);

    shift_frame_cnt #(
        .DEPTH (DEPTH)
    ) u_frame_cnt (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (w_shift_en),
        .clr       (w_clr),
        .frame_cnt (w_frame_cnt),
        .frame     (w_frame)
    );

    assign bus.pout      = r_stage;
    assign bus.sout_up   = r_stage[DEPTH-1];
    assign bus.sout_dn   = r_stage[0];
    assign bus.frame_cnt = w_frame_cnt;
    assign bus.frame     = w_frame;
endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: a 1x4 and an 8x3 instance checked every cycle
// against an array model, plus hand-computed expectations from the test plan.
module tb_shift_reg_univ;
    import shift_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_reg_univ_if #(.WIDTH(1), .DEPTH(4)) a_if ();
    shift_reg_univ_if #(.WIDTH(8), .DEPTH(3)) b_if ();

    shift_reg_univ #(.WIDTH(1), .DEPTH(4)) dut_a (.clk(clk), .reset(rst_n), .bus(a_if.slave));
    shift_reg_univ #(.WIDTH(8), .DEPTH(3)) dut_b (.clk(clk), .reset(rst_n), .bus(b_if.slave));

    int n_chk  = 0;
    int n_pass = 0;

    // Model: each word is an array of lane values; m_n counts shifts since the
    // last boundary-reset event, and the frame position is just m_n mod depth.
    int dep[2] = '{4, 3};
    int wid[2] = '{1, 8};
    int m_st[2][8];
    int m_n[2];
    bit m_fr[2];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    endtask

    function automatic void m_clear(int k);
        for (int i = 0; i < 8; i++) m_st[k][i] = 0;
        m_n[k]  = 0;
        m_fr[k] = 1'b0;
    endfunction

    function automatic void m_step(int k, int md, logic [63:0] su, logic [63:0] sd, logic [63:0] pin);
        int d;
        int msk;
        int w[8];
        d   = dep[k];
        msk = (1 << wid[k]) - 1;
        for (int i = 0; i < 8; i++) w[i] = m_st[k][i];
        m_fr[k] = 1'b0;
        case (md)
            1: begin
                for (int i = 0; i < d; i++) m_st[k][i] = (i == 0) ? (int'(su) & msk) : w[i-1];
                m_n[k]++;
                m_fr[k] = (m_n[k] % d) == 0;
            end
            2: begin
                for (int i = 0; i < d; i++) m_st[k][i] = (i == d-1) ? (int'(sd) & msk) : w[i+1];
                m_n[k]++;
                m_fr[k] = (m_n[k] % d) == 0;
            end
            3: for (int i = 0; i < d; i++) m_st[k][i] = w[(i + d - 1) % d];
            4: for (int i = 0; i < d; i++) m_st[k][i] = w[(i + 1) % d];
            5: begin
                for (int i = 0; i < d; i++) m_st[k][i] = int'(pin >> (i * wid[k])) & msk;
                m_n[k] = 0;
            end
            6: m_clear(k);
            default: ;
        endcase
    endfunction

    function automatic logic [63:0] m_pout(int k);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < dep[k]; i++) r |= 64'(m_st[k][i]) << (i * wid[k]);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clear(0);
            m_clear(1);
        end else begin
            m_step(0, int'(a_if.mode), 64'(a_if.sin_up), 64'(a_if.sin_dn), 64'(a_if.pin));
            m_step(1, int'(b_if.mode), 64'(b_if.sin_up), 64'(b_if.sin_dn), 64'(b_if.pin));
        end
    end

    always @(negedge clk) begin
        chk("a_pout",    64'(a_if.pout),      m_pout(0));
        chk("a_sout_up", 64'(a_if.sout_up),   64'(m_st[0][3]));
        chk("a_sout_dn", 64'(a_if.sout_dn),   64'(m_st[0][0]));
        chk("a_cnt",     64'(a_if.frame_cnt), 64'(m_n[0] % 4));
        chk("a_frame",   64'(a_if.frame),     64'(m_fr[0]));
        chk("b_pout",    64'(b_if.pout),      m_pout(1));
        chk("b_sout_up", 64'(b_if.sout_up),   64'(m_st[1][2]));
        chk("b_sout_dn", 64'(b_if.sout_dn),   64'(m_st[1][0]));
        chk("b_cnt",     64'(b_if.frame_cnt), 64'(m_n[1] % 3));
        chk("b_frame",   64'(b_if.frame),     64'(m_fr[1]));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drv_a(sh_mode_t md, logic su, logic sd, logic [3:0] p);
        a_if.mode = md; a_if.sin_up = su; a_if.sin_dn = sd; a_if.pin = p;
    endtask

    task automatic drv_b(sh_mode_t md, logic [7:0] su, logic [7:0] sd, logic [23:0] p);
        b_if.mode = md; b_if.sin_up = su; b_if.sin_dn = sd; b_if.pin = p;
    endtask

    function automatic sh_mode_t rnd_mode();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 4) return SH_UP;
        if (r < 6) return SH_DOWN;
        return sh_mode_t'(3'($urandom_range(0, 7)));
    endfunction

    initial begin
        int          up_seq[4]  = '{1, 0, 1, 1};
        int          up_cnt[4]  = '{1, 2, 3, 0};
        int          up_fr[4]   = '{0, 0, 0, 1};
        logic [3:0]  rot_exp[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        sh_mode_t    hm[7]      = '{SH_UP, SH_HOLD, SH_UP, SH_RSVD, SH_UP, SH_HOLD, SH_UP};
        int          h_cnt[7]   = '{1, 1, 2, 2, 3, 3, 0};
        int          h_fr[7]    = '{0, 0, 0, 0, 0, 0, 1};
        logic [3:0]  h_pout[7]  = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b1111};
        logic [23:0] b_word;

        drv_a(SH_HOLD, 1'b0, 1'b0, 4'h0);
        drv_b(SH_HOLD, 8'h0, 8'h0, 24'h0);
        repeat (2) tick();
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            drv_a(SH_UP, 1'(up_seq[i]), 1'b0, 4'h0);
            tick();
            chk("lit_up_cnt",   64'(a_if.frame_cnt), 64'(up_cnt[i]));
            chk("lit_up_frame", 64'(a_if.frame),     64'(up_fr[i]));
        end
        chk("lit_up_pout", 64'(a_if.pout),    64'(4'b1011));
        chk("lit_up_sout", 64'(a_if.sout_up), 64'd1);

        drv_a(SH_HOLD, 1'b0, 1'b0, 4'h0);
        rst_n = 1'b0;
        #1;
        chk("lit_rst_pout",  64'(a_if.pout),      64'd0);
        chk("lit_rst_sout",  64'({a_if.sout_up, a_if.sout_dn}), 64'd0);
        chk("lit_rst_cnt",   64'(a_if.frame_cnt), 64'd0);
        chk("lit_rst_frame", 64'(a_if.frame),     64'd0);
        #1;
        rst_n = 1'b1;

        drv_a(SH_LOAD, 1'b0, 1'b0, 4'b0001);
        tick();
        chk("lit_load_pout", 64'(a_if.pout), 64'(4'b0001));
        for (int i = 0; i < 4; i++) begin
            drv_a(SH_ROT_UP, 1'b0, 1'b0, 4'h0);
            tick();
            chk("lit_rot_pout",  64'(a_if.pout),      64'(rot_exp[i]));
            chk("lit_rot_cnt",   64'(a_if.frame_cnt), 64'd0);
            chk("lit_rot_frame", 64'(a_if.frame),     64'd0);
        end

        drv_a(SH_CLEAR, 1'b0, 1'b0, 4'h0);
        tick();
        drv_a(SH_DOWN, 1'b0, 1'b1, 4'h0);
        tick();
        chk("lit_dn1_pout", 64'(a_if.pout), 64'(4'b1000));
        tick();
        chk("lit_dn2_pout", 64'(a_if.pout),    64'(4'b1100));
        chk("lit_dn2_sout", 64'(a_if.sout_dn), 64'd0);
        drv_a(SH_CLEAR, 1'b0, 1'b0, 4'h0);
        tick();
        chk("lit_clr_pout", 64'(a_if.pout),      64'd0);
        chk("lit_clr_cnt",  64'(a_if.frame_cnt), 64'd0);

        for (int i = 0; i < 7; i++) begin
            drv_a(hm[i], 1'b1, 1'b0, 4'h0);
            tick();
            chk("lit_hold_pout",  64'(a_if.pout),      64'(h_pout[i]));
            chk("lit_hold_cnt",   64'(a_if.frame_cnt), 64'(h_cnt[i]));
            chk("lit_hold_frame", 64'(a_if.frame),     64'(h_fr[i]));
        end
        drv_a(SH_HOLD, 1'b0, 1'b0, 4'h0);

        for (int i = 0; i < 6; i++) begin
            drv_b(SH_UP, 8'(8'h11 * (i + 1)), 8'h0, 24'h0);
            tick();
            chk("lit_b_frame", 64'(b_if.frame), 64'((i == 2) || (i == 5)));
            if (i == 2) chk("lit_b_word1", 64'(b_if.pout), 64'(24'h112233));
            if (i == 5) chk("lit_b_word2", 64'(b_if.pout), 64'(24'h445566));
        end
        drv_b(SH_HOLD, 8'h0, 8'h0, 24'h0);
        tick();

        for (int c = 0; c < 600; c++) begin
            drv_a(rnd_mode(), 1'($urandom), 1'($urandom), 4'($urandom));
            b_word = 24'($urandom);
            drv_b(rnd_mode(), 8'($urandom), 8'($urandom), b_word);
            tick();
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
        end

        drv_a(SH_HOLD, 1'b0, 1'b0, 4'h0);
        drv_b(SH_HOLD, 8'h0, 8'h0, 24'h0);
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
